// File: rtl/mio_responder_if.sv
// CPU-side memory/IO bus of mio_responder: level request, latched response.
// The CPU drives the master side; the responder implements the slave side.
interface mio_responder_if;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output mem_r, mem_w, addr, wdata, input rdata, ready);
    modport slave  (input mem_r, mem_w, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder for a simple CPU: block RAM with fixed wait states plus
// LED, switch and free-running counter registers, one-cycle ready strobe.
module mio_responder #(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    mio_responder_if.slave bus,
    input  logic [15:0]    sw,
    output logic [15:0]    led,
    output logic           bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    typedef enum logic [2:0] {T_RAM, T_LED, T_SW, T_CNT, T_NONE} tgt_e;

    localparam logic [29:0] LED_WA    = 30'h3FFF_FFC0;
    localparam logic [29:0] SW_WA     = 30'h3FFF_FFC1;
    localparam logic [29:0] CNT_WA    = 30'h3FFF_FFC2;
    localparam logic [3:0]  WAIT_INIT = 4'(RAM_LATENCY - 1);

    function automatic tgt_e decode(input logic [31:0] a);
        if ((a >> (RAM_AW + 2)) == 32'd0) return T_RAM;
        else if (a[31:2] == LED_WA)       return T_LED;
        else if (a[31:2] == SW_WA)        return T_SW;
        else if (a[31:2] == CNT_WA)       return T_CNT;
        else                              return T_NONE;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [31:0] rdata_q, cnt_q, ram_dout_q;
    logic [15:0] led_q;
    logic        err_q;

    logic              commit, ready_c;
    logic [31:0]       cur_addr, cur_wdata, rd_mux;
    logic              cur_we;
    tgt_e              cur_tgt;
    logic [RAM_AW-1:0] cur_idx;

    logic [31:0] ram [0:(1 << RAM_AW) - 1];

    // In IDLE the live bus is the transaction (I/O commits on the sampling
    // edge); afterwards the latched copy is used.
    always_comb begin
        cur_addr  = (state_q == S_IDLE) ? bus.addr  : addr_q;
        cur_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
        cur_we    = (state_q == S_IDLE) ? bus.mem_w : we_q;
        cur_tgt   = decode(cur_addr);
        cur_idx   = cur_addr[RAM_AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        commit  = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_w || bus.mem_r) begin
                    if (cur_tgt == T_RAM) begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ready_c = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (cur_tgt)
            T_RAM:   rd_mux = ram_dout_q;
            T_LED:   rd_mux = {16'h0000, led_q};
            T_SW:    rd_mux = {16'h0000, sw};
            T_CNT:   rd_mux = cnt_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_IDLE) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.mem_w;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            led_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (commit && !cur_we) rdata_q <= rd_mux;
            if (commit && cur_we && cur_tgt == T_LED) led_q <= cur_wdata[15:0];
            if (commit && cur_we && cur_tgt == T_CNT) cnt_q <= cur_wdata;
            else                                      cnt_q <= cnt_q + 32'd1;
            if (commit && cur_tgt == T_NONE) err_q <= 1'b1;
        end
    end

    // Read port follows the transaction address every cycle, so its output is
    // already valid at the edge that leaves WAIT.
    always_ff @(posedge clk) begin
        if (commit && cur_we && cur_tgt == T_RAM) ram[cur_idx] <= cur_wdata;
        ram_dout_q <= ram[cur_idx];
    end

    assign bus.ready = ready_c;
    assign bus.rdata = rdata_q;
    assign led       = led_q;
    assign bus_err   = err_q;
endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_mio_responder;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] sw;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [15:0] exp_led;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = '0;
    logic [15:0] led;
    logic        bus_err;

    mio_responder_if bus ();

    mio_responder #(.RAM_AW(AW), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw), .led(led), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int unsigned edges = 0;
    always @(posedge clk) edges++;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_ref [int unsigned];
    logic [15:0] led_ref;
    logic        err_ref;
    logic [31:0] cnt_val;
    int unsigned cnt_edge;
    logic [31:0] last_rd;
    bit          last_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        led_ref = '0; err_ref = 1'b0; cnt_val = '0; cnt_edge = edges;
        last_rd = '0; last_known = 1'b1;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
    endtask

    // Drives one request, returns read data, edges-to-ready and sampling edge.
    task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output int unsigned e);
        bus.mem_r = r; bus.mem_w = w; bus.addr = a; bus.wdata = d;
        lat = -1; rd = '0; e = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) e = edges;
            if (bus.ready) begin
                lat = n;
                rd  = bus.rdata;
                break;
            end
        end
        bus.mem_r = 1'b0; bus.mem_w = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(bus.ready), 32'd0);
    endtask

    task automatic ref_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned e, output logic [31:0] exp_rd, output bit known,
                           output int exp_lat);
        logic [31:0] wa;
        int unsigned idx;
        wa = {a[31:2], 2'b00};
        exp_lat = 1;
        if (a < 32'(4 * (1 << AW))) begin
            exp_lat = LAT + 1;
            idx = a >> 2;
            if (w) mem_ref[idx] = d;
            else if (mem_ref.exists(idx)) begin last_rd = mem_ref[idx]; last_known = 1'b1; end
            else last_known = 1'b0;
        end else if (wa == 32'hFFFF_FF00) begin
            if (w) led_ref = d[15:0];
            else begin last_rd = {16'h0, led_ref}; last_known = 1'b1; end
        end else if (wa == 32'hFFFF_FF04) begin
            if (!w) begin last_rd = {16'h0, sw}; last_known = 1'b1; end
        end else if (wa == 32'hFFFF_FF08) begin
            if (w) begin cnt_val = d; cnt_edge = e; end
            else begin last_rd = cnt_val + 32'(e - cnt_edge - 1); last_known = 1'b1; end
        end else begin
            err_ref = 1'b1;
            if (!w) begin last_rd = '0; last_known = 1'b1; end
        end
        if (r && !w) begin end
        exp_rd = last_rd;
        known  = last_known;
    endtask

    task automatic txn_checked(input string tag, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int          lat, exp_lat;
        int unsigned e;
        logic [31:0] exp_rd;
        bit          known;
        run_txn(r, w, a, d, rd, lat, e);
        ref_txn(r, w, a, d, e, exp_rd, known, exp_lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (known) check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_led"}, 32'(led), 32'(led_ref));
        check({tag, "_bus_err"}, 32'(bus_err), 32'(err_ref));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd, exp_rd, a;
        int          lat, exp_lat;
        int unsigned e, sel, op;
        bit          known;

        bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0;
        do_reset();

        //                r     w     addr          wdata         sw       exp_rd        lat led       err
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 16'h0000, 32'h0000_0000, 3, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 32'h1234_5678, 3, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_ABCD, 16'h0000, 32'h1234_5678, 1, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FF04, 32'h0000_0000, 16'h00F0, 32'h0000_00F0, 1, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FF02, 32'h0000_0000, 16'h00F0, 32'h0000_ABCD, 1, 16'hABCD, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FF04, 32'h0000_1234, 16'h00F0, 32'h0000_ABCD, 1, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 16'h00F0, 32'h0000_ABCD, 3, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0022, 32'h0000_0000, 16'h00F0, 32'h0000_0055, 3, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 16'h00F0, 32'h1234_5678, 3, 16'hABCD, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h00F0, 32'h1234_5678, 3, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0FFF, 32'h0000_0000, 16'h00F0, 32'hCAFE_F00D, 3, 16'hABCD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 16'h00F0, 32'h0000_0000, 1, 16'hABCD, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h00F0, 32'h1234_5678, 3, 16'hABCD, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0077, 16'h00F0, 32'h1234_5678, 1, 16'hABCD, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 16'h00F0, 32'h0000_0000, 1, 16'hABCD, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FF0C, 32'h0000_0005, 16'h00F0, 32'h0000_0000, 1, 16'hABCD, 1'b1});

        foreach (vecs[i]) begin
            sw = vecs[i].sw;
            run_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, rd, lat, e);
            ref_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, e, exp_rd, known, exp_lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(vecs[i].exp_err));
        end

        // Counter wrap: load, 3 idle cycles, read back.
        txn_checked("cnt_load", 1'b0, 1'b1, 32'hFFFF_FF08, 32'hFFFF_FFFE, rd);
        repeat (3) @(posedge clk);
        #1;
        txn_checked("cnt_read", 1'b1, 1'b0, 32'hFFFF_FF08, 32'h0, rd);
        check("cnt_wrap_value", rd, 32'h0000_0002);

        // Level-held read restarts every LAT+2 cycles.
        bus.mem_r = 1'b1; bus.addr = 32'h0000_0010;
        for (int k = 1; k <= 2 * int'(LAT + 2); k++) begin
            @(posedge clk); #1;
            check($sformatf("level_ready_k%0d", k), 32'(bus.ready),
                  32'((k % int'(LAT + 2)) == int'(LAT + 1)));
            if (bus.ready) check("level_rdata", bus.rdata, 32'h1234_5678);
        end
        bus.mem_r = 1'b0;

        // A request raised during WAIT is ignored.
        bus.mem_r = 1'b1; bus.addr = 32'h0000_0010;
        @(posedge clk); #1;
        bus.mem_r = 1'b0; bus.mem_w = 1'b1; bus.addr = 32'hFFFF_FF00; bus.wdata = 32'h0000_1111;
        @(posedge clk); #1;
        check("ign_wait_ready", 32'(bus.ready), 32'd0);
        bus.mem_w = 1'b0;
        @(posedge clk); #1;
        check("ign_ready", 32'(bus.ready), 32'd1);
        check("ign_rdata", bus.rdata, 32'h1234_5678);
        check("ign_led", 32'(led), 32'h0000_ABCD);
        @(posedge clk); #1;
        check("ign_ready_low", 32'(bus.ready), 32'd0);
        last_rd = 32'h1234_5678; last_known = 1'b1;

        // Reset during WAIT of a RAM write leaves the old word in place.
        txn_checked("pre30", 1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_0001, rd);
        bus.mem_w = 1'b1; bus.addr = 32'h0000_0030; bus.wdata = 32'h0000_0099;
        @(posedge clk); #1;
        check("abort_wait_ready0", 32'(bus.ready), 32'd0);
        bus.mem_w = 1'b0;
        @(posedge clk); #1;
        check("abort_wait_ready1", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_async_led", 32'(led), 32'd0);
        check("abort_async_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        check("abort_rst_ready", 32'(bus.ready), 32'd0);
        do_reset();
        txn_checked("post30", 1'b1, 1'b0, 32'h0000_0030, 32'h0, rd);
        check("post30_value", rd, 32'hA5A5_0001);

        // Randomized traffic against the model.
        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
                2:    a = 32'hFFFF_FF00 + $urandom_range(0, 3);
                3:    a = 32'hFFFF_FF04 + $urandom_range(0, 3);
                4:    a = 32'hFFFF_FF08 + $urandom_range(0, 3);
                default: a = (t % 2 == 0) ? 32'h0000_1000 + ($urandom & 32'h00FF_FFFC)
                                          : 32'hFFFF_FF0C + $urandom_range(0, 3);
            endcase
            op = $urandom_range(0, 2);
            sw = 16'($urandom);
            txn_checked($sformatf("rnd%0d", t), op != 1, op != 0, a, $urandom, rd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter RAM_AW, default 10, RAM word-address width (2^RAM_AW 32-bit words).
REQ-002 Parameter RAM_LATENCY, default 2, wait cycles for RAM access; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_r  input  1  CPU read request, level.
REQ-006 mem_w  input  1  CPU write request, level.
REQ-007 addr  input  32  CPU byte address (CPU M_addr).
REQ-008 wdata  input  32  CPU store data (CPU data_out).
REQ-009 rdata  output  32  read data to CPU (CPU data2CPU).
REQ-010 ready  output  1  transaction-complete strobe to CPU (CPU MIO_ready).
REQ-011 sw  input  16  board switches.
REQ-012 led  output  16  LED register.
REQ-013 bus_err  output  1  sticky unmapped-access flag.

Function
REQ-014 Address map: addr < 4*2^RAM_AW -> RAM, index addr[RAM_AW+1:2]; 0xFFFF_FF00 LED (RW, bits 15:0); 0xFFFF_FF04 SW (RO, zero-extended); 0xFFFF_FF08 CNT (RW); all else unmapped.
REQ-015 addr[1:0] SHALL be ignored (word access only).
REQ-016 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: if mem_w or mem_r sampled high, latch addr, wdata, direction; both high -> write (read dropped).
REQ-018 IDLE -> WAIT for RAM target, wait counter loaded with RAM_LATENCY-1; IDLE -> RESP for I/O or unmapped target.
REQ-019 WAIT: counter decrements each cycle; at zero -> RESP.
REQ-020 RESP: ready=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-021 Latency: ready high exactly L+1 cycles after the request-sampling edge; L=RAM_LATENCY for RAM, 0 otherwise.
REQ-022 ready SHALL be 0 in IDLE and WAIT.
REQ-023 Requests arriving in WAIT or RESP SHALL be ignored; no queueing.
REQ-024 A request still high when FSM returns to IDLE starts a new transaction (level-sensitive).
REQ-025 Read: rdata updated on the edge entering RESP; valid while ready=1; held until the next read completes.
REQ-026 Write: commit to RAM/LED/CNT on the edge entering RESP; rdata unchanged by writes.
REQ-027 SW writes SHALL be ignored (no error).
REQ-028 CNT increments by 1 each cycle, wraps 0xFFFF_FFFF -> 0; a committing CNT write loads wdata and overrides the increment that cycle.
REQ-029 CNT read returns value registered at RESP entry.
REQ-030 Unmapped access: completes normally with ready; read returns 0x0000_0000; write discarded; bus_err set to 1 and held.
REQ-031 RAM SHALL be inferrable as synchronous block RAM; contents not reset.

Reset
REQ-032 On rst: state IDLE, ready 0, rdata 0, led 0, CNT 0, bus_err 0, wait counter 0.
REQ-033 rst during WAIT or RESP abandons the transaction; an uncommitted write SHALL NOT modify RAM/LED/CNT.
REQ-034 First request sampled on first rising edge after rst deasserts.

Verification
REQ-035 RAM write 0x1234_5678 to 0x10, then read 0x10, RAM_LATENCY=2 -> ready 3 cycles after each request edge; rdata=0x1234_5678.
REQ-036 Write 0xABCD to 0xFFFF_FF00 -> led=0xABCD after 1-cycle latency; sw=0x00F0, read 0xFFFF_FF04 -> rdata=0x0000_00F0.
REQ-037 Write 0xFFFF_FFFE to 0xFFFF_FF08, idle 3 cycles, read CNT -> value consistent with wrap (0x0000_0001..0x0000_0003 range per exact timing).
REQ-038 Read 0x8000_0000 -> ready after 1 cycle, rdata=0, bus_err=1 and stays 1 until rst.
REQ-039 mem_r and mem_w both high to RAM 0x20 with wdata 0x55 -> write performed; later read 0x20 returns 0x55.
REQ-040 Assert rst in WAIT of RAM write 0x99 to 0x30 -> ready never pulses; read 0x30 after reset returns prior contents.
